dma_desc_queue: RTL and testbench

Descriptor queue and issue sequencer placed directly upstream of the ROM-to-RAM DMA engine. Software-side logic pushes transfer descriptors (source address, destination address, element count). The block buffers them in a small FIFO and issues them to the DMA one at a time. It drives the DMA's start/srcAddr/destAddr/data_amt inputs and consumes its done output.

---
 rtl/dma_desc_queue.sv | 138 +++++++++++++
 tb/tb_dma_desc_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_queue.sv
// Descriptor FIFO and issue sequencer feeding a ROM-to-RAM DMA engine.
// Buffers {src, dst, len} descriptors and launches them one at a time, skipping zero-length entries.
module dma_desc_queue #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_valid,
   output logic                   push_ready,
   input  logic [ADDR_W-1:0]      push_src,
   input  logic [ADDR_W-1:0]      push_dst,
   input  logic [LEN_W-1:0]       push_len,
   output logic                   dma_start,
   output logic [ADDR_W-1:0]      dma_src_addr,
   output logic [ADDR_W-1:0]      dma_dest_addr,
   output logic [LEN_W-1:0]       dma_data_amt,
   input  logic                   dma_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic [CNT_W-1:0]       completed_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int QW = PW + 1;
   localparam int EW = 2 * ADDR_W + LEN_W;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [EW-1:0]     r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [QW-1:0]     r_count;
   logic [CNT_W-1:0]  r_completed;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_len;

   logic              w_push;
   logic              w_pop;
   logic              w_retire;
   logic [EW-1:0]     w_head;
   logic [ADDR_W-1:0] w_head_src;
   logic [ADDR_W-1:0] w_head_dst;
   logic [LEN_W-1:0]  w_head_len;

   // Head is read combinationally so a pop loads the DMA registers on the same edge.
   assign w_head     = r_mem[r_rd_ptr];
   assign w_head_src = w_head[EW-1 -: ADDR_W];
   assign w_head_dst = w_head[LEN_W +: ADDR_W];
   assign w_head_len = w_head[LEN_W-1:0];

   assign push_ready = (r_count < QW'(DEPTH));
   assign w_push     = push_valid && push_ready;

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop = 1'b1;
               if (w_head_len == '0) begin
                  w_retire = 1'b1;
               end else begin
                  w_state_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (dma_done) begin
               w_retire     = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {push_src, push_dst, push_len};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_completed <= '0;
         r_src       <= '0;
         r_dst       <= '0;
         r_len       <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + QW'(1);
            2'b01:   r_count <= r_count - QW'(1);
            default: r_count <= r_count;
         endcase
         if (w_retire) begin
            r_completed <= r_completed + CNT_W'(1);
         end
         // Transfer registers hold the last issued descriptor until the next real launch.
         if (w_pop && (w_head_len != '0)) begin
            r_src <= w_head_src;
            r_dst <= w_head_dst;
            r_len <= w_head_len;
         end
      end
   end

   assign dma_start       = (r_state == S_ISSUE);
   assign dma_src_addr    = r_src;
   assign dma_dest_addr   = r_dst;
   assign dma_data_amt    = r_len;
   assign busy            = (r_state != S_IDLE) || (r_count != '0);
   assign queue_count     = r_count;
   assign completed_count = r_completed;

endmodule

// File: tb/tb_dma_desc_queue.sv
// Self-checking bench for dma_desc_queue: directed scenarios plus randomized traffic
// checked against a descriptor-queue reference model.
module tb_dma_desc_queue;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [31:0] src;
      logic [31:0] dst;
      logic [31:0] len;
   } desc_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              push_valid = 1'b0;
   logic [ADDR_W-1:0] push_src = '0;
   logic [ADDR_W-1:0] push_dst = '0;
   logic [LEN_W-1:0]  push_len = '0;
   logic              dma_done = 1'b0;
   logic              push_ready;
   logic              dma_start;
   logic [ADDR_W-1:0] dma_src_addr;
   logic [ADDR_W-1:0] dma_dest_addr;
   logic [LEN_W-1:0]  dma_data_amt;
   logic              busy;
   logic [$clog2(DEPTH):0] queue_count;
   logic [CNT_W-1:0]  completed_count;

   int          tests = 0;
   int          fails = 0;
   logic [CNT_W-1:0] exp_completed = '0;
   desc_t       model_q[$];

   dma_desc_queue #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_src(push_src), .push_dst(push_dst), .push_len(push_len),
      .dma_start(dma_start), .dma_src_addr(dma_src_addr),
      .dma_dest_addr(dma_dest_addr), .dma_data_amt(dma_data_amt),
      .dma_done(dma_done), .busy(busy),
      .queue_count(queue_count), .completed_count(completed_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit q_has_work();
      foreach (model_q[i]) if (model_q[i].len != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive_desc(input desc_t d);
      push_src = d.src;
      push_dst = d.dst;
      push_len = d.len;
   endtask

   task automatic test_reset();
      rst = 1'b1; push_valid = 1'b0; dma_done = 1'b0;
      step(); step();
      rst = 1'b0;
      exp_completed = '0;
      model_q.delete();
      tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL reset_push_ready got=%b want=1", push_ready); end
      tests++; if (dma_start !== 1'b0) begin fails++; $display("FAIL reset_dma_start got=%b want=0", dma_start); end
      tests++; if ({dma_src_addr, dma_dest_addr, dma_data_amt} !== '0) begin
         fails++; $display("FAIL reset_dma_regs got=%h/%h/%h want=0", dma_src_addr, dma_dest_addr, dma_data_amt); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
      tests++; if (queue_count !== 3'd0) begin fails++; $display("FAIL reset_queue_count got=%0d want=0", queue_count); end
      tests++; if (completed_count !== 16'd0) begin fails++; $display("FAIL reset_completed got=%0d want=0", completed_count); end
   endtask

   task automatic test_single();
      push_src = 32'h10; push_dst = 32'h80; push_len = 32'd5; push_valid = 1'b1;
      tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL single_ready got=%b want=1", push_ready); end
      step();
      push_valid = 1'b0;
      tests++; if (dma_start !== 1'b0 || queue_count !== 3'd1) begin
         fails++; $display("FAIL single_accept start=%b qc=%0d want start=0 qc=1", dma_start, queue_count); end
      step();
      tests++; if (dma_start !== 1'b1 || dma_src_addr !== 32'h10 || dma_dest_addr !== 32'h80 || dma_data_amt !== 32'd5) begin
         fails++; $display("FAIL single_issue start=%b %h/%h/%0d want 1 10/80/5", dma_start, dma_src_addr, dma_dest_addr, dma_data_amt); end
      $display("[TB] single issue src=%h dst=%h len=%0d", dma_src_addr, dma_dest_addr, dma_data_amt);
      step();
      tests++; if (dma_start !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL single_wait start=%b busy=%b want 0/1", dma_start, busy); end
      step(); step();
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      exp_completed++;
      tests++; if (completed_count !== exp_completed || busy !== 1'b0) begin
         fails++; $display("FAIL single_done completed=%0d busy=%b want %0d/0", completed_count, busy, exp_completed); end
      tests++; if (dma_src_addr !== 32'h10 || dma_data_amt !== 32'd5) begin
         fails++; $display("FAIL single_hold src=%h amt=%0d want 10/5", dma_src_addr, dma_data_amt); end
   endtask

   // Random pushes and DMA completions; every launch is compared with the model queue head.
   task automatic run_traffic(input int n_new, input int zero_pct, input int dmin, input int dmax, input bit busy_in);
      int    pushed = 0;
      int    timer = 0;
      int    cyc = 0;
      bit    pend = 1'b0;
      bit    in_flight;
      bit    acc;
      bit    done_now;
      bit    have_cur = 1'b0;
      desc_t nxt;
      desc_t cur;
      desc_t exp;
      in_flight = busy_in;
      while ((pushed < n_new || pend || in_flight || q_has_work()) && cyc < 5000) begin
         if (!pend && pushed < n_new && $urandom_range(0, 2) != 0) begin
            nxt.src = $urandom;
            nxt.dst = $urandom;
            nxt.len = ($urandom_range(0, 99) < zero_pct) ? 32'd0 : 32'($urandom_range(1, 1000));
            drive_desc(nxt);
            pend = 1'b1;
         end
         push_valid = pend;
         done_now = in_flight && (timer == 0);
         dma_done = done_now;
         acc = pend && push_ready;
         step();
         cyc++;
         dma_done = 1'b0;
         if (done_now) begin
            in_flight = 1'b0;
            have_cur = 1'b0;
            exp_completed++;
         end else if (in_flight && timer > 0) begin
            timer--;
         end
         if (dma_start) begin
            while (model_q.size() > 0 && model_q[0].len == 0) begin
               void'(model_q.pop_front());
               exp_completed++;
            end
            tests++;
            if (in_flight || model_q.size() == 0) begin
               fails++; $display("FAIL traffic_unexpected_start in_flight=%b queued=%0d", in_flight, model_q.size());
            end else begin
               exp = model_q.pop_front();
               if (dma_src_addr !== exp.src || dma_dest_addr !== exp.dst || dma_data_amt !== exp.len) begin
                  fails++; $display("FAIL traffic_issue got=%h/%h/%0d want=%h/%h/%0d",
                     dma_src_addr, dma_dest_addr, dma_data_amt, exp.src, exp.dst, exp.len);
               end
               $display("[TB] issue src=%h dst=%h len=%0d", dma_src_addr, dma_dest_addr, dma_data_amt);
               cur = exp; have_cur = 1'b1; in_flight = 1'b1;
               timer = 1 + $urandom_range(dmin, dmax);
            end
         end else if (have_cur) begin
            tests++;
            if (dma_src_addr !== cur.src || dma_dest_addr !== cur.dst || dma_data_amt !== cur.len) begin
               fails++; $display("FAIL traffic_hold got=%h/%h/%0d want=%h/%h/%0d",
                  dma_src_addr, dma_dest_addr, dma_data_amt, cur.src, cur.dst, cur.len);
            end
         end
         if (acc) begin
            model_q.push_back(nxt);
            pend = 1'b0;
            pushed++;
         end
      end
      push_valid = 1'b0;
      if (cyc >= 5000) begin
         tests++; fails++; $display("FAIL traffic_timeout cycles=%0d limit=5000", cyc);
      end
      repeat (2 * DEPTH + 2) step();
      while (model_q.size() > 0) begin
         void'(model_q.pop_front());
         exp_completed++;
      end
      tests++; if (queue_count !== 3'd0 || busy !== 1'b0 || dma_start !== 1'b0) begin
         fails++; $display("FAIL traffic_drain qc=%0d busy=%b start=%b want 0/0/0", queue_count, busy, dma_start); end
      tests++; if (completed_count !== exp_completed) begin
         fails++; $display("FAIL traffic_completed got=%0d want=%0d", completed_count, exp_completed); end
   endtask

   task automatic test_fill();
      desc_t d[6];
      desc_t e;
      for (int i = 0; i < 6; i++) begin
         d[i].src = 32'h1000 + 32'(i * 16);
         d[i].dst = 32'h2000 + 32'(i * 16);
         d[i].len = 32'(i + 1);
      end
      dma_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive_desc(d[c]); push_valid = 1'b1;
         tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_%0d got=%b want=1", c, push_ready); end
         step();
         model_q.push_back(d[c]);
         tests++; if (dma_start !== (c == 1)) begin fails++; $display("FAIL fill_start_%0d got=%b want=%b", c, dma_start, (c == 1)); end
         if (c == 1) begin
            e = model_q.pop_front();
            tests++; if (dma_src_addr !== e.src || dma_data_amt !== e.len) begin
               fails++; $display("FAIL fill_first got=%h/%0d want=%h/%0d", dma_src_addr, dma_data_amt, e.src, e.len); end
         end
      end
      drive_desc(d[5]);
      tests++; if (push_ready !== 1'b0 || queue_count !== 3'd4) begin
         fails++; $display("FAIL fill_full ready=%b qc=%0d want 0/4", push_ready, queue_count); end
      repeat (3) begin
         step();
         tests++; if (push_ready !== 1'b0 || dma_start !== 1'b0) begin
            fails++; $display("FAIL fill_hold ready=%b start=%b want 0/0", push_ready, dma_start); end
      end
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      exp_completed++;
      tests++; if (push_ready !== 1'b0 || dma_start !== 1'b0) begin
         fails++; $display("FAIL fill_done_edge ready=%b start=%b want 0/0", push_ready, dma_start); end
      step();
      e = model_q.pop_front();
      tests++; if (dma_start !== 1'b1 || dma_src_addr !== e.src || queue_count !== 3'd3 || push_ready !== 1'b1) begin
         fails++; $display("FAIL fill_next_pop start=%b src=%h qc=%0d ready=%b want 1/%h/3/1",
            dma_start, dma_src_addr, queue_count, push_ready, e.src); end
      step();
      model_q.push_back(d[5]);
      push_valid = 1'b0;
      tests++; if (queue_count !== 3'd4) begin fails++; $display("FAIL fill_sixth qc=%0d want=4", queue_count); end
      run_traffic(0, 0, 0, 2, 1'b1);
   endtask

   task automatic test_zero_len();
      desc_t d[3];
      int    starts = 0;
      int    done_at = -1;
      logic [31:0] amt = '0;
      d[0] = '{src: 32'hA0, dst: 32'hB0, len: 32'd0};
      d[1] = '{src: 32'hA4, dst: 32'hB4, len: 32'd7};
      d[2] = '{src: 32'hA8, dst: 32'hB8, len: 32'd0};
      for (int c = 0; c < 20; c++) begin
         if (c < 3) begin
            drive_desc(d[c]); push_valid = 1'b1;
            tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL zero_ready_%0d got=%b want=1", c, push_ready); end
         end else begin
            push_valid = 1'b0;
         end
         dma_done = (c == done_at);
         step();
         dma_done = 1'b0;
         if (dma_start) begin
            starts++; amt = dma_data_amt; done_at = c + 2;
         end
      end
      exp_completed = exp_completed + 16'd3;
      tests++; if (starts != 1 || amt !== 32'd7) begin fails++; $display("FAIL zero_starts got=%0d amt=%0d want 1/7", starts, amt); end
      tests++; if (completed_count !== exp_completed) begin
         fails++; $display("FAIL zero_completed got=%0d want=%0d", completed_count, exp_completed); end
      tests++; if (busy !== 1'b0 || queue_count !== 3'd0) begin
         fails++; $display("FAIL zero_idle busy=%b qc=%0d want 0/0", busy, queue_count); end
   endtask

   task automatic test_wrap();
      logic [CNT_W-1:0] base;
      base = exp_completed;
      run_traffic(10, 0, 1, 1, 1'b0);
      tests++; if (completed_count !== base + 16'd10) begin
         fails++; $display("FAIL wrap_completed got=%0d want=%0d", completed_count, base + 16'd10); end
   endtask

   task automatic test_random();
      run_traffic(40, 25, 0, 4, 1'b0);
   endtask

   task automatic test_spurious_reset();
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      tests++; if (completed_count !== exp_completed || busy !== 1'b0 || dma_start !== 1'b0) begin
         fails++; $display("FAIL spurious_idle completed=%0d busy=%b start=%b want %0d/0/0",
            completed_count, busy, dma_start, exp_completed); end
      push_src = 32'h300; push_dst = 32'h400; push_len = 32'd9; push_valid = 1'b1;
      step();
      push_valid = 1'b0;
      step();
      tests++; if (dma_start !== 1'b1) begin fails++; $display("FAIL spurious_start got=%b want=1", dma_start); end
      dma_done = 1'b1;
      push_src = 32'h310; push_dst = 32'h410; push_len = 32'd3; push_valid = 1'b1;
      step();
      dma_done = 1'b0;
      push_src = 32'h320; push_dst = 32'h420; push_len = 32'd4;
      step();
      push_valid = 1'b0;
      step();
      tests++; if (completed_count !== exp_completed || busy !== 1'b1 || queue_count !== 3'd2) begin
         fails++; $display("FAIL spurious_issue completed=%0d busy=%b qc=%0d want %0d/1/2",
            completed_count, busy, queue_count, exp_completed); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_completed = '0;
      model_q.delete();
      tests++; if (push_ready !== 1'b1 || dma_start !== 1'b0 || busy !== 1'b0 || queue_count !== 3'd0 ||
                   completed_count !== 16'd0 || {dma_src_addr, dma_dest_addr, dma_data_amt} !== '0) begin
         fails++; $display("FAIL midreset ready=%b start=%b busy=%b qc=%0d comp=%0d regs=%h/%h/%h want 1/0/0/0/0/0",
            push_ready, dma_start, busy, queue_count, completed_count, dma_src_addr, dma_dest_addr, dma_data_amt); end
      for (int c = 0; c < 10; c++) begin
         step();
         tests++; if (dma_start !== 1'b0 || queue_count !== 3'd0) begin
            fails++; $display("FAIL midreset_quiet_%0d start=%b qc=%0d want 0/0", c, dma_start, queue_count); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_zero_len();
      test_wrap();
      test_random();
      test_spurious_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
